// File: rtl/lvds_tx.sv
// LVDS I/Q transmitter: pulls 32-bit I/Q words from a registered-read FIFO and sends each one as a 32-bit frame, 2 bits per clock, MSB first.
// Optional build macro LVDS_TX_TEST_PATTERN_EN adds an internal I/Q ramp generator selected by i_test_mode.
module lvds_tx #(
  parameter int UNDERRUN_W = 8
) (
  input  logic                  i_ddr_clk,
  input  logic                  i_rst_b,
  input  logic                  i_tx_en,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_pull,
  input  logic [31:0]           i_fifo_data,
  output logic [1:0]            o_ddr_data,
  output logic [UNDERRUN_W-1:0] o_underrun_cnt,
  input  logic                  i_test_mode,
  output logic [1:0]            o_debug_state
);

  // FIFO handshake: o_fifo_pull is a one-cycle read strobe, raised only when
  // i_fifo_empty=0; the FIFO presents the word on i_fifo_data the next cycle.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

  localparam logic [31:0] ZERO_FRAME = 32'h8000_4000;

  function automatic logic [31:0] build_frame(input logic [12:0] i_v, input logic [12:0] q_v);
    return {2'b10, i_v, 1'b0, 2'b01, q_v, 1'b0};
  endfunction

  state_e                state_q, state_d;
  logic [3:0]            phase_q, phase_d;
  logic [31:0]           shift_q, shift_d;
  logic [31:0]           next_q, next_d;
  logic [1:0]            ddr_q, ddr_d;
  logic                  pulled_q, pulled_d;
  logic [UNDERRUN_W-1:0] under_q, under_d;
  logic                  pull_c;
  logic                  test_c;
  logic [31:0]           fifo_frame_c;
  logic                  unused_data_c;

`ifdef LVDS_TX_TEST_PATTERN_EN
  logic [12:0] ramp_q, ramp_d;
  logic [31:0] ramp_frame_c;
  assign test_c       = i_test_mode;
  assign ramp_frame_c = build_frame(ramp_q, ~ramp_q);
`else
  logic unused_test_c;
  assign test_c        = 1'b0;
  assign unused_test_c = i_test_mode;
`endif

  assign fifo_frame_c  = build_frame(i_fifo_data[28:16], i_fifo_data[12:0]);
  assign unused_data_c = ^{i_fifo_data[31:29], i_fifo_data[15:13]};

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    shift_d  = shift_q;
    next_d   = next_q;
    ddr_d    = ddr_q;
    pulled_d = pulled_q;
    under_d  = under_q;
    pull_c   = 1'b0;
`ifdef LVDS_TX_TEST_PATTERN_EN
    ramp_d   = ramp_q;
`endif
    case (state_q)
      ST_IDLE: begin
        ddr_d    = 2'b00;
        phase_d  = 4'd0;
        pulled_d = 1'b0;
        if (i_tx_en) begin
`ifdef LVDS_TX_TEST_PATTERN_EN
          if (test_c) begin
            state_d = ST_STREAM;
            ddr_d   = ramp_frame_c[31:30];
            shift_d = {ramp_frame_c[29:0], 2'b00};
            ramp_d  = ramp_q + 13'd1;
          end else
`endif
          if (!i_fifo_empty) begin
            pull_c  = 1'b1;
            state_d = ST_PRIME;
          end
        end
      end
      ST_PRIME: begin
        // First frame bypasses the next-frame register so its first dibit is not delayed.
        next_d  = fifo_frame_c;
        ddr_d   = fifo_frame_c[31:30];
        shift_d = {fifo_frame_c[29:0], 2'b00};
        phase_d = 4'd0;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        phase_d = phase_q + 4'd1;
        ddr_d   = shift_q[31:30];
        shift_d = {shift_q[29:0], 2'b00};
        if (phase_q == 4'd13) begin
          pulled_d = 1'b0;
          if (i_tx_en && !i_fifo_empty && !test_c) begin
            pull_c   = 1'b1;
            pulled_d = 1'b1;
          end
        end
        if (phase_q == 4'd14) begin
`ifdef LVDS_TX_TEST_PATTERN_EN
          if (test_c) begin
            next_d = ramp_frame_c;
            ramp_d = ramp_q + 13'd1;
          end else
`endif
          if (pulled_q) begin
            next_d = fifo_frame_c;
          end else begin
            next_d = ZERO_FRAME;
            if (under_q != {UNDERRUN_W{1'b1}}) under_d = under_q + 1'b1;
          end
        end
        if (phase_q == 4'd15) begin
          phase_d = 4'd0;
          if (i_tx_en) begin
            ddr_d   = next_q[31:30];
            shift_d = {next_q[29:0], 2'b00};
          end else begin
            ddr_d   = 2'b00;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        ddr_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state_q  <= ST_IDLE;
      phase_q  <= 4'd0;
      shift_q  <= 32'd0;
      next_q   <= 32'd0;
      ddr_q    <= 2'b00;
      pulled_q <= 1'b0;
      under_q  <= '0;
`ifdef LVDS_TX_TEST_PATTERN_EN
      ramp_q   <= 13'd0;
`endif
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      shift_q  <= shift_d;
      next_q   <= next_d;
      ddr_q    <= ddr_d;
      pulled_q <= pulled_d;
      under_q  <= under_d;
`ifdef LVDS_TX_TEST_PATTERN_EN
      ramp_q   <= ramp_d;
`endif
    end
  end

  // Strobe is combinational (FIFO needs it a cycle before capture); held low while in reset.
  assign o_fifo_pull    = pull_c & i_rst_b;
  assign o_ddr_data     = ddr_q;
  assign o_underrun_cnt = under_q;
  assign o_debug_state  = state_q;

endmodule

// File: tb/tb_lvds_tx.sv
// Directed testbench for lvds_tx: registered-read FIFO model, frame capture by dibit, pull-timing log.
module tb_lvds_tx;

  logic        clk;
  logic        rst_b;
  logic        tx_en;
  logic        fifo_empty;
  logic        fifo_pull;
  logic [31:0] fifo_data;
  logic [1:0]  ddr_data;
  logic [7:0]  underrun_cnt;
  logic        test_mode;
  logic [1:0]  debug_state;

  int checks = 0;
  int errors = 0;

  lvds_tx #(.UNDERRUN_W(8)) dut (
    .i_ddr_clk      (clk),
    .i_rst_b        (rst_b),
    .i_tx_en        (tx_en),
    .i_fifo_empty   (fifo_empty),
    .o_fifo_pull    (fifo_pull),
    .i_fifo_data    (fifo_data),
    .o_ddr_data     (ddr_data),
    .o_underrun_cnt (underrun_cnt),
    .i_test_mode    (test_mode),
    .o_debug_state  (debug_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model with registered read
  logic [31:0] mem [0:15];
  logic [31:0] wr_ptr = 0;
  logic [31:0] rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_pull && !fifo_empty) begin
      fifo_data <= mem[rd_ptr[3:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // pull log and protocol monitor
  int cyc = 0;
  int pull_log[$];
  logic bad_pull = 1'b0;
  logic pull_prev = 1'b0;

  always @(posedge clk) begin
    if (fifo_pull) pull_log.push_back(cyc);
    if (fifo_pull && (fifo_empty || pull_prev)) bad_pull <= 1'b1;
    pull_prev <= fifo_pull;
    cyc <= cyc + 1;
  end

  // driver tasks
  task automatic push(input logic [31:0] d);
    mem[wr_ptr[3:0]] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_pull(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (fifo_pull) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(tag, {31'd0, found}, 32'd1);
  endtask

  task automatic wait_state(input string tag, input logic [1:0] s, input int max_cyc);
    logic found;
    found = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (debug_state == s) begin
        found = 1'b1;
        break;
      end
    end
    chk(tag, {31'd0, found}, 32'd1);
  endtask

  // Call at the negedge of a frame's first dibit; returns at the next frame's first dibit.
  task automatic get_frame(output logic [31:0] f, input int drop_p);
    f = 32'd0;
    for (int k = 0; k < 16; k++) begin
      if (k == drop_p) tx_en = 1'b0;
      f = {f[29:0], ddr_data};
      @(negedge clk);
    end
  endtask

  logic [31:0] f;
  logic [13:0] part;
  int          s_cyc;
  int          base;

  initial begin
    rst_b     = 1'b0;
    tx_en     = 1'b0;
    test_mode = 1'b0;
    fifo_data = 32'd0;
    repeat (4) @(negedge clk);

    // reset state
    chk("rst_ddr", {30'd0, ddr_data}, 32'd0);
    chk("rst_pull", {31'd0, fifo_pull}, 32'd0);
    chk("rst_cnt", {24'd0, underrun_cnt}, 32'd0);
    chk("rst_state", {30'd0, debug_state}, 32'd0);
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_hold", {30'd0, debug_state}, 32'd0);

    // single word, then underrun frames
    push(32'h1555_0AAA);
    tx_en = 1'b1;
    wait_pull("first_pull");
    @(negedge clk);
    chk("prime_state", {30'd0, debug_state}, 32'd1);
    @(negedge clk);
    get_frame(f, -1);
    chk("single_frame", f, 32'hAAAA_5554);
    get_frame(f, -1);
    chk("zero_frame", f, 32'h8000_4000);
    chk("cnt_after_two", {24'd0, underrun_cnt}, 32'd2);
    chk("stream_state", {30'd0, debug_state}, 32'd2);

    // back-to-back: pulls at p=13, 16 cycles apart, contiguous frames
    s_cyc = cyc;
    base  = pull_log.size();
    push(32'hE001_FFFF);
    push(32'h1FFF_0000);
    push(32'h0ABC_1234);
    get_frame(f, -1);
    chk("b2b_lead_zero", f, 32'h8000_4000);
    get_frame(f, -1);
    chk("b2b_frame_a", f, 32'h8002_7FFE);
    get_frame(f, -1);
    chk("b2b_frame_b", f, 32'hBFFE_4000);
    get_frame(f, -1);
    chk("b2b_frame_c", f, 32'h9578_6468);
    get_frame(f, -1);
    chk("b2b_tail_zero", f, 32'h8000_4000);
    chk("b2b_pull_count", pull_log.size() - base, 32'd3);
    if (pull_log.size() - base == 3) begin
      chk("b2b_pull0_phase", pull_log[base] - s_cyc, 32'd13);
      chk("b2b_pull_gap1", pull_log[base+1] - pull_log[base], 32'd16);
      chk("b2b_pull_gap2", pull_log[base+2] - pull_log[base+1], 32'd16);
    end
    chk("b2b_cnt", {24'd0, underrun_cnt}, 32'd4);

    // underrun saturation
    repeat (250) get_frame(f, -1);
    chk("sat_zero_frame", f, 32'h8000_4000);
    chk("cnt_fe", {24'd0, underrun_cnt}, 32'h0FE);
    get_frame(f, -1);
    chk("cnt_ff", {24'd0, underrun_cnt}, 32'h0FF);
    repeat (60) get_frame(f, -1);
    chk("cnt_sat_hold", {24'd0, underrun_cnt}, 32'h0FF);

    // disable at p=5: frame completes, then idle with no pulls
    push(32'h0F0F_10F0);
    get_frame(f, -1);
    base = pull_log.size();
    get_frame(f, 5);
    chk("dis_frame", f, 32'h9E1E_61E0);
    chk("dis_ddr", {30'd0, ddr_data}, 32'd0);
    chk("dis_state", {30'd0, debug_state}, 32'd0);
    push(32'h0123_1ABC);
    repeat (20) @(negedge clk);
    chk("dis_no_pull", pull_log.size() - base, 32'd0);
    chk("dis_ddr_hold", {30'd0, ddr_data}, 32'd0);

    // reset at p=7
    tx_en = 1'b1;
    wait_pull("rst_run_pull");
    repeat (2) @(negedge clk);
    part = 14'd0;
    for (int k = 0; k < 7; k++) begin
      part = {part[11:0], ddr_data};
      @(negedge clk);
    end
    chk("rst_partial", {18'd0, part}, 32'h2091);
    rst_b = 1'b0;
    #1;
    chk("mid_rst_ddr", {30'd0, ddr_data}, 32'd0);
    chk("mid_rst_pull", {31'd0, fifo_pull}, 32'd0);
    chk("mid_rst_cnt", {24'd0, underrun_cnt}, 32'd0);
    chk("mid_rst_state", {30'd0, debug_state}, 32'd0);
    push(32'h1000_0001);
    @(negedge clk);
    rst_b = 1'b1;
    wait_pull("restart_pull");
    @(negedge clk);
    chk("restart_prime", {30'd0, debug_state}, 32'd1);
    @(negedge clk);
    get_frame(f, -1);
    chk("restart_frame", f, 32'hA000_4002);
    chk("restart_cnt", {24'd0, underrun_cnt}, 32'd1);

    // stop streaming: the in-flight zero frame counts one more underrun
    tx_en = 1'b0;
    wait_state("stop_idle", 2'd0, 40);
    chk("stop_cnt", {24'd0, underrun_cnt}, 32'd2);

`ifdef LVDS_TX_TEST_PATTERN_EN
    // internal ramp pattern
    base      = pull_log.size();
    test_mode = 1'b1;
    tx_en     = 1'b1;
    wait_state("tp_stream", 2'd2, 4);
    get_frame(f, -1);
    chk("tp_frame0", f, 32'h8000_7FFE);
    get_frame(f, -1);
    chk("tp_frame1", f, 32'h8002_7FFC);
    get_frame(f, -1);
    chk("tp_frame2", f, 32'h8004_7FFA);
    chk("tp_no_pull", pull_log.size() - base, 32'd0);
    chk("tp_cnt", {24'd0, underrun_cnt}, 32'd2);
    tx_en = 1'b0;
    wait_state("tp_stop", 2'd0, 40);
`else
    // test_mode ignored: empty FIFO keeps the block idle, no underruns counted
    test_mode = 1'b1;
    tx_en     = 1'b1;
    repeat (20) @(negedge clk);
    chk("tm_ignored_state", {30'd0, debug_state}, 32'd0);
    chk("tm_ignored_cnt", {24'd0, underrun_cnt}, 32'd2);
    chk("tm_ignored_ddr", {30'd0, ddr_data}, 32'd0);
    tx_en = 1'b0;
`endif

    chk("pull_rules", {31'd0, bad_pull}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
